// File: rtl/grf_mp_bypass.sv
// General register file: NRD combinational read ports with write-to-read bypass,
// a per-register busy scoreboard (claim at issue, clear at writeback) and a busy count.
module grf_mp_bypass #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 5,
  parameter int unsigned   NRD     = 2,
  parameter int unsigned   GP_IDX  = 28,
  parameter logic [DW-1:0] GP_INIT = 32'h0000_1800,
  parameter int unsigned   SP_IDX  = 29,
  parameter logic [DW-1:0] SP_INIT = 32'h0000_0ffc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [31:0]       wpc,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              claim,
  input  logic [AW-1:0]     claim_addr,
  input  logic              flush,
  output logic [AW:0]       nbusy
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      r_nbusy;
  logic [AW:0]      w_cnt_nxt;
  logic             w_wr;
  logic             w_clm;
  logic             w_byp_en;
  logic             w_unused_wpc;

  // wpc only tags the writeback for tracing; the datapath never looks at it.
  assign w_unused_wpc = ^wpc;

  assign w_wr     = we && (waddr != '0);
  assign w_clm    = claim && (claim_addr != '0);
  // No write is accepted while reset is low, so the bypass must not show one either.
  assign w_byp_en = we && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == GP_IDX)      r_regs[i] <= GP_INIT;
        else if (i == SP_IDX) r_regs[i] <= SP_INIT;
        else                  r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Order sets priority: claim overrides writeback clear, flush overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)  w_busy_nxt[waddr]      = 1'b0;
    if (w_clm) w_busy_nxt[claim_addr] = 1'b1;
    if (flush) w_busy_nxt             = '0;
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= '0;
      r_nbusy <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_nbusy <= w_cnt_nxt;
    end
  end

  assign nbusy = r_nbusy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    assign w_ra  = raddr[k*AW +: AW];
    assign w_hit = w_byp_en && (waddr == w_ra);
    assign rdata[k*DW +: DW] = (w_ra == '0) ? '0 :
                               w_hit        ? wdata : r_regs[w_ra];
    assign rbusy[k] = (w_ra != '0) && r_busy[w_ra] && !w_hit;
  end

endmodule

// File: tb/tb_grf_mp_bypass.sv
// Scoreboard bench for grf_mp_bypass: expectations are queued as stimulus is driven
// and compared against the DUT outputs once they have settled.
module tb_grf_mp_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] wpc;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        claim;
  logic [4:0]  claim_addr;
  logic        flush;
  logic [5:0]  nbusy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];

  grf_mp_bypass #(.DW(32), .AW(5), .NRD(2)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .claim(claim),
    .claim_addr(claim_addr), .flush(flush), .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sel: 0 rdata port0, 1 rdata port1, 2 rbusy, 3 nbusy
  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       obs = rdata[31:0];
        1:       obs = rdata[63:32];
        2:       obs = {30'b0, rbusy};
        default: obs = {26'b0, nbusy};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic idle();
    we = 1'b0; claim = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wpc = '0;
    claim = 1'b0; claim_addr = '0; flush = 1'b0;
    set_rd(5'd28, 5'd29);
    #12;
    expect_val("rst_gp", 0, 32'h0000_1800);
    expect_val("rst_sp", 1, 32'h0000_0ffc);
    expect_val("rst_nbusy", 3, 32'd0);
    drain();

    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    expect_val("post_rst_gp", 0, 32'h0000_1800);
    expect_val("post_rst_sp", 1, 32'h0000_0ffc);
    drain();
    set_rd(5'd1, 5'd31);
    expect_val("post_rst_r1", 0, 32'd0);
    expect_val("post_rst_r31", 1, 32'd0);
    expect_val("post_rst_rbusy", 2, 32'd0);
    drain();

    // write with same-cycle bypass on both ports
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; wpc = 32'h0000_0100;
    set_rd(5'd5, 5'd5);
    expect_val("byp_p0", 0, 32'hDEAD_BEEF);
    expect_val("byp_p1", 1, 32'hDEAD_BEEF);
    drain();
    @(negedge clk); idle();
    expect_val("stored_r5", 0, 32'hDEAD_BEEF);
    drain();

    // write to register 0 is ignored, also for bypass
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    set_rd(5'd0, 5'd5);
    expect_val("r0_byp", 0, 32'd0);
    drain();
    @(negedge clk); idle();
    expect_val("r0_after", 0, 32'd0);
    expect_val("r0_nbusy", 3, 32'd0);
    drain();

    // claim then writeback
    @(negedge clk);
    claim = 1'b1; claim_addr = 5'd7; set_rd(5'd7, 5'd0);
    expect_val("clm7_pre_rbusy", 2, 32'd0);
    drain();
    @(negedge clk); idle();
    expect_val("clm7_rbusy", 2, 32'd1);
    expect_val("clm7_nbusy", 3, 32'd1);
    drain();
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12;
    expect_val("wb7_rbusy", 2, 32'd0);
    expect_val("wb7_byp", 0, 32'h12);
    expect_val("wb7_nbusy_pre", 3, 32'd1);
    drain();
    @(negedge clk); idle();
    expect_val("wb7_nbusy", 3, 32'd0);
    expect_val("wb7_data", 0, 32'h12);
    drain();

    // claim 0 never makes anything busy
    @(negedge clk);
    claim = 1'b1; claim_addr = 5'd0;
    @(negedge clk); idle(); set_rd(5'd0, 5'd0);
    expect_val("clm0_nbusy", 3, 32'd0);
    expect_val("clm0_rbusy", 2, 32'd0);
    drain();

    // claim and write same register on the same edge: claim wins, data written
    @(negedge clk);
    claim = 1'b1; claim_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    @(negedge clk); idle(); set_rd(5'd9, 5'd0);
    expect_val("cw9_data", 0, 32'h99);
    expect_val("cw9_rbusy", 2, 32'd1);
    expect_val("cw9_nbusy", 3, 32'd1);
    drain();
    @(negedge clk); claim = 1'b1; claim_addr = 5'd3;
    @(negedge clk); claim_addr = 5'd4;
    @(negedge clk); idle(); set_rd(5'd3, 5'd4);
    expect_val("clm34_rbusy", 2, 32'd3);
    expect_val("clm34_nbusy", 3, 32'd3);
    drain();

    // flush beats a same-cycle claim; a same-cycle write still lands
    @(negedge clk);
    flush = 1'b1; claim = 1'b1; claim_addr = 5'd6;
    we = 1'b1; waddr = 5'd11; wdata = 32'h55;
    @(negedge clk); idle(); set_rd(5'd6, 5'd9);
    expect_val("fl_nbusy", 3, 32'd0);
    expect_val("fl_rbusy", 2, 32'd0);
    expect_val("fl_keep9", 1, 32'h99);
    drain();
    set_rd(5'd11, 5'd3);
    expect_val("fl_wr11", 0, 32'h55);
    expect_val("fl_rbusy3", 2, 32'd0);
    drain();

    // reset asserted mid-cycle with a claim pending and a write on the bus
    @(negedge clk); claim = 1'b1; claim_addr = 5'd10;
    @(negedge clk); idle();
    we = 1'b1; waddr = 5'd10; wdata = 32'hAA; set_rd(5'd10, 5'd5);
    expect_val("pre_rst_byp", 0, 32'hAA);
    expect_val("pre_rst_nbusy", 3, 32'd1);
    drain();
    #1 reset = 1'b0;
    expect_val("mid_rst_r10", 0, 32'd0);
    expect_val("mid_rst_r5", 1, 32'd0);
    expect_val("mid_rst_rbusy", 2, 32'd0);
    expect_val("mid_rst_nbusy", 3, 32'd0);
    drain();
    @(negedge clk);
    expect_val("rst_nowr_r10", 0, 32'd0);
    drain();
    idle(); reset = 1'b1; set_rd(5'd10, 5'd28);
    expect_val("rel_r10", 0, 32'd0);
    expect_val("rel_gp", 1, 32'h0000_1800);
    drain();
    @(negedge clk);
    we = 1'b1; waddr = 5'd10; wdata = 32'h77;
    @(negedge clk); idle();
    expect_val("rel_wr10", 0, 32'h77);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
